bus6502_ram_ctrl: RTL and testbench



---
 rtl/bus6502_pkg.sv | 19 +
 rtl/bus6502_sync.sv | 43 ++++
 rtl/bus6502_ram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bus6502_ram_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus6502_pkg.sv
// Shared constants for the 6502-side RAM controller: register map,
// CTRL bit positions and arbiter state encoding.
package bus6502_pkg;

   localparam logic [3:0] REG_ADDR    = 4'd0;
   localparam logic [3:0] REG_DATA    = 4'd1;
   localparam logic [3:0] REG_CTRL    = 4'd2;
   localparam logic [3:0] REG_SCANLEN = 4'd3;
   localparam logic [3:0] REG_LED     = 4'd4;

   localparam int CTRL_SCAN_EN = 0;
   localparam int CTRL_AUTOINC = 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CPU_WR   = 2'd1;
   localparam logic [1:0] ST_SCAN_RD  = 2'd2;
   localparam logic [1:0] ST_SCAN_CAP = 2'd3;

endpackage

// File: rtl/bus6502_sync.sv
// Synchronizer bank for the asynchronous 6502 bus pins plus phi2
// falling-edge detect. rs and data are stable while phi2 is high, so
// they are synchronized bit by bit alongside the strobes.
module bus6502_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_ext1,
   input  logic       cs,
   input  logic       wren,
   input  logic [3:0] rs,
   input  logic [7:0] data_in,
   output logic       cpu_evt,
   output logic [3:0] rs_s,
   output logic [7:0] data_s
);

   localparam int W = 15;

   logic [W-1:0] sync_q [SYNC_STAGES];
   logic [W-1:0] bus_s;
   logic         phi2_d;

   // shift all bus pins through the synchronizer chain; keep last phi2 for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         phi2_d <= 1'b0;
      end else begin
         sync_q[0] <= {clk_ext1, cs, wren, rs, data_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         phi2_d <= bus_s[14];
      end
   end

   assign bus_s   = sync_q[SYNC_STAGES-1];
   // phi2 fall with chip selected and a write cycle; cs and wren are active low
   assign cpu_evt = phi2_d & ~bus_s[14] & ~bus_s[13] & ~bus_s[12];
   assign rs_s    = bus_s[11:8];
   assign data_s  = bus_s[7:0];

endmodule

// File: rtl/bus6502_ram_ctrl.sv
// RAM controller/arbiter between the 6502 register interface and the
// 256x8 RAM. CPU writes are queued in a single pending slot; a scan
// engine periodically reads RAM and replays it onto the LEDs.
//
//   state       | meaning
//   ------------+---------------------------------------------
//   ST_IDLE     | no RAM access; pick CPU write, then scan read
//   ST_CPU_WR   | one-cycle RAM write of wr_addr/wr_dat
//   ST_SCAN_RD  | present scan_ptr to the RAM
//   ST_SCAN_CAP | capture ram_q into led, advance scan_ptr
module bus6502_ram_ctrl
   import bus6502_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_ext1,
   input  logic       cs,
   input  logic [3:0] rs,
   input  logic       wren,
   input  logic [7:0] data_in,
   output logic [7:0] ram_address,
   output logic [7:0] ram_data,
   output logic       ram_wren,
   input  logic [7:0] ram_q,
   output logic [7:0] led,
   output logic       overrun
);

   localparam int TW = $clog2(SCAN_DIV);

   logic          cpu_evt;
   logic [3:0]    rs_s;
   logic [7:0]    data_s;
   logic [1:0]    state;
   logic [7:0]    addr_reg, ctrl_reg, scan_len, led_reg;
   logic [7:0]    wr_addr, wr_dat, scan_ptr, addr_hold, addr_nxt;
   logic          wr_pend, scan_pend;
   logic [TW-1:0] tick_cnt;
   logic          tick_tc, grant, scan_en;
   logic          ev_addr, ev_data, ev_ctrl, ev_len, ev_led;
   logic          unused_ctrl;

   bus6502_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .clk_ext1 (clk_ext1),
      .cs       (cs),
      .wren     (wren),
      .rs       (rs),
      .data_in  (data_in),
      .cpu_evt  (cpu_evt),
      .rs_s     (rs_s),
      .data_s   (data_s)
   );

   assign ev_addr = cpu_evt && (rs_s == REG_ADDR);
   assign ev_data = cpu_evt && (rs_s == REG_DATA);
   assign ev_ctrl = cpu_evt && (rs_s == REG_CTRL);
   assign ev_len  = cpu_evt && (rs_s == REG_SCANLEN);
   assign ev_led  = cpu_evt && (rs_s == REG_LED);

   assign grant   = (state == ST_CPU_WR);
   assign scan_en = ctrl_reg[CTRL_SCAN_EN];
   assign tick_tc = (tick_cnt == TW'(SCAN_DIV - 1));

   // upper CTRL bits are held for software but drive nothing
   assign unused_ctrl = ^ctrl_reg[7:2];

   // next CPU pointer: an explicit ADDR write beats the post-grant increment
   always_comb begin
      addr_nxt = addr_reg;
      if (ev_addr)
         addr_nxt = data_s;
      else if (grant && ctrl_reg[CTRL_AUTOINC])
         addr_nxt = addr_reg + 8'd1;
   end

   // CPU-visible registers and the single pending-write slot
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg <= '0;
         ctrl_reg <= '0;
         scan_len <= '0;
         led_reg  <= '0;
         wr_pend  <= 1'b0;
         wr_addr  <= '0;
         wr_dat   <= '0;
         overrun  <= 1'b0;
      end else begin
         addr_reg <= addr_nxt;
         if (ev_ctrl) ctrl_reg <= data_s;
         if (ev_len)  scan_len <= data_s;
         if (ev_led)  led_reg  <= data_s;
         if (ev_data) begin
            wr_pend <= 1'b1;
            wr_addr <= addr_nxt;
            wr_dat  <= data_s;
            // a write landing in the grant cycle simply re-queues; only an unserved one is lost
            if (wr_pend && !grant) overrun <= 1'b1;
         end else if (grant) begin
            wr_pend <= 1'b0;
         end
      end
   end

   // free-running scan divider; requests only while scanning is enabled
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         scan_pend <= 1'b0;
      end else begin
         tick_cnt <= tick_tc ? '0 : tick_cnt + TW'(1);
         if (tick_tc && scan_en)
            scan_pend <= 1'b1;
         else if (!scan_en || state == ST_SCAN_CAP)
            scan_pend <= 1'b0;
      end
   end

   // arbiter FSM, scan pointer and LED source selection
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         scan_ptr  <= '0;
         led       <= '0;
         addr_hold <= '0;
      end else begin
         addr_hold <= ram_address;
         case (state)
            ST_IDLE: begin
               if (wr_pend)        state <= ST_CPU_WR;
               else if (scan_pend) state <= ST_SCAN_RD;
            end
            ST_CPU_WR:  state <= ST_IDLE;
            ST_SCAN_RD: state <= ST_SCAN_CAP;
            default:    state <= ST_IDLE;
         endcase
         // >= so that shrinking SCAN_LEN below the pointer wraps on the next advance
         if (ev_ctrl && data_s[CTRL_SCAN_EN])
            scan_ptr <= '0;
         else if (state == ST_SCAN_CAP)
            scan_ptr <= (scan_ptr >= scan_len) ? 8'd0 : scan_ptr + 8'd1;
         if (state == ST_SCAN_CAP)
            led <= ram_q;
         else if (!scan_en)
            led <= ev_led ? data_s : led_reg;
      end
   end

   // RAM port drive; address holds between accesses, write suppressed under reset
   always_comb begin
      ram_address = addr_hold;
      ram_data    = '0;
      ram_wren    = 1'b0;
      case (state)
         ST_CPU_WR: begin
            ram_address = wr_addr;
            ram_data    = wr_dat;
            ram_wren    = ~rst;
         end
         ST_SCAN_RD: ram_address = scan_ptr;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus6502_ram_ctrl.sv
// Directed bench for bus6502_ram_ctrl with a behavioural 256x8 RAM.
module tb_bus6502_ram_ctrl;
   import bus6502_pkg::*;

   localparam int SCAN_DIV = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_clr = 1'b1;
   logic       clk_ext1 = 1'b0;
   logic       cs = 1'b1;
   logic [3:0] rs = '0;
   logic       wren = 1'b1;
   logic [7:0] data_in = '0;
   logic [7:0] ram_address, ram_data, led;
   logic [7:0] ram_q = '0;
   logic       ram_wren, overrun;

   logic [7:0] mem [256];
   logic [7:0] scan_exp [4];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int last_wr_cyc = 0;
   int fall_cyc = 0;
   logic [7:0] last_wa = '0;
   logic [7:0] last_wd = '0;

   always #10 clk = ~clk;

   bus6502_ram_ctrl #(.SCAN_DIV(SCAN_DIV), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_ext1    (clk_ext1),
      .cs          (cs),
      .rs          (rs),
      .wren        (wren),
      .data_in     (data_in),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .led         (led),
      .overrun     (overrun)
   );

   // synchronous-read RAM model
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else begin
         if (ram_wren) mem[ram_address] <= ram_data;
         ram_q <= mem[ram_address];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // write monitor
   always @(negedge clk) begin
      if (ram_wren) begin
         wr_cnt      <= wr_cnt + 1;
         last_wa     <= ram_address;
         last_wd     <= ram_data;
         last_wr_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one bus cycle: phi2 high with address/data, then phi2 falls
   task automatic bus_wr(input logic cs_v, input logic wren_v, input logic [3:0] rs_v,
                         input logic [7:0] d_v);
      @(posedge clk); #3;
      cs = cs_v; wren = wren_v; rs = rs_v; data_in = d_v; clk_ext1 = 1'b1;
      repeat (8) @(posedge clk);
      #7;
      clk_ext1 = 1'b0;
      fall_cyc = cyc;
      repeat (8) @(posedge clk);
      #3;
      cs = 1'b1; wren = 1'b1;
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (dut.state == st) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_led(input int budget, output bit ok);
      logic [7:0] prev;
      prev = led;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (led !== prev) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int c0, prev_cyc;
      scan_exp[0] = 8'h01; scan_exp[1] = 8'h02; scan_exp[2] = 8'h04; scan_exp[3] = 8'h01;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst0_led", led, 8'h00);
      chk("rst0_addr", ram_address, 8'h00);
      chk("rst0_data", ram_data, 8'h00);
      chk("rst0_wren", ram_wren, 1'b0);
      chk("rst0_ovr", overrun, 1'b0);
      chk("rst0_state", dut.state, ST_IDLE);
      rst = 1'b0; mem_clr = 1'b0;
      repeat (4) @(posedge clk);

      // CPU writes with autoincrement
      bus_wr(0, 0, REG_ADDR, 8'h10);
      bus_wr(0, 0, REG_CTRL, 8'h02);
      bus_wr(0, 0, REG_DATA, 8'hAA);
      chk("wr1_cnt", wr_cnt, 1);
      chk("wr1_addr", last_wa, 8'h10);
      chk("wr1_data", last_wd, 8'hAA);
      chk("wr1_lat", (last_wr_cyc - fall_cyc) <= 5, 1'b1);
      bus_wr(0, 0, REG_DATA, 8'h55);
      chk("wr2_cnt", wr_cnt, 2);
      chk("wr2_addr", last_wa, 8'h11);
      chk("wr2_data", last_wd, 8'h55);
      chk("wr2_lat", (last_wr_cyc - fall_cyc) <= 5, 1'b1);
      bus_wr(0, 0, REG_CTRL, 8'h00);
      bus_wr(0, 0, REG_DATA, 8'h77);
      chk("addr_end", last_wa, 8'h12);

      // ignored accesses
      bus_wr(1, 0, REG_ADDR, 8'h99);
      bus_wr(0, 1, REG_ADDR, 8'h99);
      bus_wr(0, 0, 4'd9, 8'h99);
      bus_wr(1, 0, REG_LED, 8'h5A);
      bus_wr(0, 1, REG_LED, 8'h5A);
      chk("ign_cnt", wr_cnt, 3);
      chk("ign_led", led, 8'h00);
      bus_wr(0, 0, REG_DATA, 8'h33);
      chk("ign_addr", last_wa, 8'h12);
      chk("ign_data", last_wd, 8'h33);
      bus_wr(0, 0, REG_LED, 8'hC3);
      chk("led_direct", led, 8'hC3);

      // scan replay of RAM 0..2
      bus_wr(0, 0, REG_ADDR, 8'h00);
      bus_wr(0, 0, REG_CTRL, 8'h02);
      bus_wr(0, 0, REG_DATA, 8'h01);
      bus_wr(0, 0, REG_DATA, 8'h02);
      bus_wr(0, 0, REG_DATA, 8'h04);
      bus_wr(0, 0, REG_SCANLEN, 8'h02);
      bus_wr(0, 0, REG_CTRL, 8'h01);
      chk("pre_cnt", wr_cnt, 7);
      prev_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_led(3 * SCAN_DIV, ok);
         chk("scan_to", ok, 1'b1);
         chk("scan_led", led, scan_exp[i]);
         if (i > 0) chk("scan_period", cyc - prev_cyc, SCAN_DIV);
         prev_cyc = cyc;
      end

      // DATA event in the same cycle the scan tick fires
      ok = 1'b0;
      for (int i = 0; i < 2 * SCAN_DIV; i++) begin
         @(posedge clk); #1;
         if (dut.tick_cnt == SCAN_DIV - 1) begin ok = 1'b1; break; end
      end
      chk("coll_align", ok, 1'b1);
      force dut.rs_s = REG_DATA;
      force dut.data_s = 8'h99;
      force dut.cpu_evt = 1'b1;
      @(posedge clk); #1;
      release dut.cpu_evt;
      release dut.rs_s;
      release dut.data_s;
      @(posedge clk); #1;
      chk("coll_wren", ram_wren, 1'b1);
      chk("coll_waddr", ram_address, 8'h03);
      chk("coll_wdata", ram_data, 8'h99);
      repeat (2) @(posedge clk);
      #1;
      chk("coll_rd", dut.state, ST_SCAN_RD);
      chk("coll_raddr", ram_address, 8'h01);
      repeat (2) @(posedge clk);
      #1;
      chk("coll_led", led, 8'h02);
      chk("coll_ovr", overrun, 1'b0);
      chk("coll_cnt", wr_cnt, 8);

      // reset in the middle of a scan read
      wait_state(ST_SCAN_RD, 2 * SCAN_DIV, ok);
      chk("rst_align", ok, 1'b1);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_led", led, 8'h00);
      chk("rst_addr", ram_address, 8'h00);
      chk("rst_data", ram_data, 8'h00);
      chk("rst_wren", ram_wren, 1'b0);
      chk("rst_state", dut.state, ST_IDLE);
      rst = 1'b0;
      c0 = wr_cnt;
      repeat (2 * SCAN_DIV) @(posedge clk);
      #1;
      chk("rst_nowr", wr_cnt, c0);
      chk("rst_led_hold", led, 8'h00);

      // address wrap and overrun
      bus_wr(0, 0, REG_ADDR, 8'hFF);
      bus_wr(0, 0, REG_CTRL, 8'h02);
      bus_wr(0, 0, REG_DATA, 8'h11);
      chk("wrap_a0", last_wa, 8'hFF);
      chk("wrap_d0", last_wd, 8'h11);
      bus_wr(0, 0, REG_DATA, 8'h22);
      chk("wrap_a1", last_wa, 8'h00);
      chk("wrap_d1", last_wd, 8'h22);
      chk("wrap_ovr", overrun, 1'b0);
      c0 = wr_cnt;
      @(posedge clk); #1;
      force dut.rs_s = REG_DATA;
      force dut.data_s = 8'hA1;
      force dut.cpu_evt = 1'b1;
      @(posedge clk); #1;
      force dut.data_s = 8'hA2;
      @(posedge clk); #1;
      release dut.cpu_evt;
      release dut.rs_s;
      release dut.data_s;
      repeat (6) @(posedge clk);
      #1;
      chk("ovr_cnt", wr_cnt, c0 + 1);
      chk("ovr_addr", last_wa, 8'h01);
      chk("ovr_data", last_wd, 8'hA2);
      chk("ovr_flag", overrun, 1'b1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
